// File: rtl/sort_store.sv
// -----------------------------------------------------------------------------
// sort_store -- AXI4 write-back stage of the hdl_sort engine.
//
// On an accepted store_start the block captures the result vector, start
// address, PASID and beat count, then writes N 1024-bit beats to host memory.
// Beat k goes to addr + 128*k and carries slice (N-1-k) of store_data, which
// undoes the packing of the fetch stage. store_done is raised only after every
// write response has come back; store_error latches any non-OKAY bresp.
//
// Configuration macro: SORT_STORE_BURST_EN
//   defined   : one INCR burst, awlen = N-1, a single B response.
//   undefined : N single-beat writes, awlen = 0, wlast on every beat.
//
// Ports:
//   clk, rst_n (async, active-low)
//   store_start / store_start_addr / store_pasid / store_beat_num / store_data
//                                  : request, sampled when accepted
//   store_done  : level, high in DONE
//   store_error : sticky non-OKAY response flag, cleared by the next start
//   m_axi_aw*, m_axi_w*, m_axi_b*  : AXI4 write master channels
// -----------------------------------------------------------------------------
module sort_store #(
    parameter int ID_WIDTH     = 1,
    parameter int AWUSER_WIDTH = 9,
    parameter int PASID_WIDTH  = 9,
    parameter int STORE_WIDTH  = 32768,
    parameter int DATA_WIDTH   = 1024,
    parameter int ADDR_WIDTH   = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      store_start,
    input  logic [ADDR_WIDTH-1:0]     store_start_addr,
    input  logic [PASID_WIDTH-1:0]    store_pasid,
    input  logic [5:0]                store_beat_num,
    input  logic [STORE_WIDTH-1:0]    store_data,
    output logic                      store_done,
    output logic                      store_error,
    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic [AWUSER_WIDTH-1:0]   m_axi_awuser,
    output logic [3:0]                m_axi_awcache,
    output logic                      m_axi_awlock,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic [3:0]                m_axi_awregion,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);

    localparam int MAX_BEATS = STORE_WIDTH / DATA_WIDTH;
    localparam int SEL_W     = $clog2(MAX_BEATS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]              state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [PASID_WIDTH-1:0]  pasid_reg;
    logic [5:0]              beat_num_reg;
    logic [STORE_WIDTH-1:0]  data_reg;
    logic [5:0]              aw_cnt_reg, w_cnt_reg, b_cnt_reg;
    logic                    error_reg;

    logic                    start_accept;
    logic                    aw_hs, w_hs, b_hs;
    logic [5:0]              xfer_total;
    logic [5:0]              slice_sel;
    logic [DATA_WIDTH-1:0]   slices [MAX_BEATS];

    // A start is only honoured outside RUN; a start during RUN is dropped.
    assign start_accept = store_start && (state_reg != ST_RUN);

`ifdef SORT_STORE_BURST_EN
    // One burst, so one AW and one B regardless of N.
    assign xfer_total  = (beat_num_reg != 6'd0) ? 6'd1 : 6'd0;
    assign m_axi_awlen = (beat_num_reg != 6'd0) ? {2'b00, beat_num_reg - 6'd1} : 8'd0;
    assign m_axi_wlast = m_axi_wvalid && (w_cnt_reg == beat_num_reg - 6'd1);
`else
    // Every beat is its own single-beat transaction.
    assign xfer_total  = beat_num_reg;
    assign m_axi_awlen = 8'd0;
    assign m_axi_wlast = m_axi_wvalid;
`endif

    assign m_axi_awvalid = (state_reg == ST_RUN) && (aw_cnt_reg < xfer_total);
    assign m_axi_wvalid  = (state_reg == ST_RUN) && (w_cnt_reg < beat_num_reg);

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    // Responses outside RUN or beyond the expected count are ignored.
    assign b_hs  = (state_reg == ST_RUN) && m_axi_bvalid && (b_cnt_reg < xfer_total);

    // Beat addresses step by 128 bytes.
    assign m_axi_awaddr = addr_reg + (ADDR_WIDTH'(aw_cnt_reg) << 7);

    // The first-written beat lives in the most significant used slice.
    assign slice_sel = beat_num_reg - w_cnt_reg - 6'd1;

    generate
        for (genvar gi = 0; gi < MAX_BEATS; gi++) begin : g_slice
            assign slices[gi] = data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign m_axi_wdata = slices[slice_sel[SEL_W-1:0]];

    assign m_axi_awid     = '0;
    assign m_axi_awsize   = 3'd7;
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awuser   = AWUSER_WIDTH'(pasid_reg);
    assign m_axi_awcache  = 4'd3;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awprot   = 3'd0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;
    assign m_axi_wstrb    = '1;
    assign m_axi_bready   = 1'b1;

    assign store_done  = (state_reg == ST_DONE);
    assign store_error = error_reg;

    // bid carries nothing useful (awid is constant); slice_sel MSB is only
    // needed for the subtraction.
    logic unused_bits;
    assign unused_bits = ^{m_axi_bid, slice_sel[5]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start_accept) begin
                    state_next = (store_beat_num == 6'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (b_hs && (b_cnt_reg + 6'd1 == xfer_total)) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            pasid_reg    <= '0;
            beat_num_reg <= '0;
            aw_cnt_reg   <= '0;
            w_cnt_reg    <= '0;
            b_cnt_reg    <= '0;
            error_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_accept) begin
                addr_reg     <= store_start_addr;
                pasid_reg    <= store_pasid;
                beat_num_reg <= store_beat_num;
                aw_cnt_reg   <= '0;
                w_cnt_reg    <= '0;
                b_cnt_reg    <= '0;
                error_reg    <= 1'b0;
            end else begin
                if (aw_hs) aw_cnt_reg <= aw_cnt_reg + 6'd1;
                if (w_hs)  w_cnt_reg  <= w_cnt_reg + 6'd1;
                if (b_hs) begin
                    b_cnt_reg <= b_cnt_reg + 6'd1;
                    if (m_axi_bresp != 2'b00) error_reg <= 1'b1;
                end
            end
        end
    end

    // Wide payload capture needs no reset: it is only observed while wvalid.
    always_ff @(posedge clk) begin
        if (start_accept) begin
            data_reg <= store_data;
        end
    end

endmodule

// File: tb/tb_sort_store.sv
module tb_sort_store;

    localparam int DW = 1024;
    localparam int SW = 32768;
`ifdef SORT_STORE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            store_start = 1'b0;
    logic [63:0]     store_start_addr = '0;
    logic [8:0]      store_pasid = '0;
    logic [5:0]      store_beat_num = '0;
    logic [SW-1:0]   store_data = '0;
    logic            store_done, store_error;
    logic [0:0]      m_axi_awid;
    logic [63:0]     m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic [8:0]      m_axi_awuser;
    logic [3:0]      m_axi_awcache;
    logic            m_axi_awlock;
    logic [2:0]      m_axi_awprot;
    logic [3:0]      m_axi_awqos;
    logic [3:0]      m_axi_awregion;
    logic            m_axi_awvalid;
    logic            m_axi_awready = 1'b0;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast, m_axi_wvalid;
    logic            m_axi_wready = 1'b0;
    logic [0:0]      m_axi_bid = '0;
    logic [1:0]      m_axi_bresp = 2'b00;
    logic            m_axi_bvalid = 1'b0;
    logic            m_axi_bready;

    sort_store dut (
        .clk(clk), .rst_n(rst_n),
        .store_start(store_start), .store_start_addr(store_start_addr),
        .store_pasid(store_pasid), .store_beat_num(store_beat_num),
        .store_data(store_data), .store_done(store_done), .store_error(store_error),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awuser(m_axi_awuser),
        .m_axi_awcache(m_axi_awcache), .m_axi_awlock(m_axi_awlock), .m_axi_awprot(m_axi_awprot),
        .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard queues, pushed at start, popped at handshakes
    logic [63:0]   exp_aw_addr_q [$];
    logic [7:0]    exp_aw_len_q  [$];
    logic [DW-1:0] exp_w_data_q  [$];
    logic          exp_w_last_q  [$];

    // slave configuration (driver-owned)
    int       cfg_n = 0, cfg_b_total = 0, run_id = 0, start_cyc = 0;
    bit       cfg_stall = 0, cfg_err_last = 0, force_b = 0;
    logic [8:0] cfg_pasid = '0;

    // slave statistics (slave-owned)
    int       aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, seen_id = 0, b_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got low64 %h expected low64 %h (cycle %0d)", nm, act[63:0], exp[63:0], cyc);
        end
    endtask

    // ---------------- slave: readies/B driven and handshakes observed at negedge
    initial begin
        bit            aw_hold = 0, w_hold = 0;
        logic [63:0]   h_addr;
        logic [DW-1:0] h_data;
        logic          h_last;
        int            pend;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
                aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; aw_hold = 0; w_hold = 0;
                exp_aw_addr_q.delete(); exp_aw_len_q.delete();
                exp_w_data_q.delete(); exp_w_last_q.delete();
            end else begin
                if (seen_id != run_id) begin
                    seen_id = run_id;
                    aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; b_cyc = 0; aw_hold = 0; w_hold = 0;
                end
                // B channel
                if (force_b) begin
                    m_axi_bvalid = 1; m_axi_bresp = 2'b10;
                end else begin
                    if (BURST) pend = (aw_hs_n >= 1 && cfg_n > 0 && w_hs_n == cfg_n) ? 1 : 0;
                    else       pend = (aw_hs_n < w_hs_n) ? aw_hs_n : w_hs_n;
                    pend = pend - b_hs_n;
                    if (pend > 0 && (!cfg_stall || $urandom_range(0, 1) == 1)) begin
                        m_axi_bvalid = 1;
                        m_axi_bresp  = (cfg_err_last && b_hs_n == cfg_b_total - 1) ? 2'b10 : 2'b00;
                        b_hs_n++;
                        b_cyc = cyc;
                    end else begin
                        m_axi_bvalid = 0; m_axi_bresp = 2'b00;
                    end
                end
                // AW channel: under stall, AW is held off early so W leads
                m_axi_awready = !cfg_stall || ((cyc - start_cyc > 4) && $urandom_range(0, 2) != 0);
                if (m_axi_awvalid) begin
                    if (aw_hold) chk("aw_addr_stable", m_axi_awaddr, h_addr);
                    if (m_axi_awready) begin
                        if (exp_aw_addr_q.size() == 0) chk("aw_unexpected", 1, 0);
                        else begin
                            chk("aw_addr", m_axi_awaddr, exp_aw_addr_q.pop_front());
                            chk("aw_len", 64'(m_axi_awlen), 64'(exp_aw_len_q.pop_front()));
                            chk("aw_user", 64'(m_axi_awuser), 64'(cfg_pasid));
                        end
                        aw_hs_n++;
                        aw_hold = 0;
                    end else begin
                        aw_hold = 1; h_addr = m_axi_awaddr;
                    end
                end else begin
                    if (aw_hold) chk("aw_valid_held", 0, 1);
                    aw_hold = 0;
                end
                // W channel
                m_axi_wready = !cfg_stall || $urandom_range(0, 2) != 0;
                if (m_axi_wvalid) begin
                    if (w_hold) begin
                        chk_data("w_data_stable", m_axi_wdata, h_data);
                        chk("w_last_stable", 64'(m_axi_wlast), 64'(h_last));
                    end
                    if (m_axi_wready) begin
                        if (exp_w_data_q.size() == 0) chk("w_unexpected", 1, 0);
                        else begin
                            chk_data("w_data", m_axi_wdata, exp_w_data_q.pop_front());
                            chk("w_last", 64'(m_axi_wlast), 64'(exp_w_last_q.pop_front()));
                        end
                        w_hs_n++;
                        w_hold = 0;
                    end else begin
                        w_hold = 1; h_data = m_axi_wdata; h_last = m_axi_wlast;
                    end
                end else begin
                    if (w_hold) chk("w_valid_held", 0, 1);
                    w_hold = 0;
                end
            end
        end
    end

    // ---------------- driver
    typedef struct {
        int          n;
        logic [63:0] addr;
        bit          stall;
        bit          err_last;
        bit          exp_error;
    } vec_t;

    int exp_aw_total;

    // called at a negedge; returns at the next negedge (first RUN cycle)
    task automatic start_store(input int n, input logic [63:0] addr, input bit stall, input bit err_last);
        logic [DW-1:0] sv [32];
        for (int j = 0; j < 32; j++)
            for (int w = 0; w < DW / 32; w++)
                sv[j][w*32 +: 32] = $urandom;
        for (int j = 0; j < 32; j++) store_data[j*DW +: DW] = sv[j];
        cfg_n = n; cfg_stall = stall; cfg_err_last = err_last;
        cfg_b_total  = (n == 0) ? 0 : (BURST ? 1 : n);
        exp_aw_total = cfg_b_total;
        cfg_pasid = 9'($urandom);
        if (n > 0) begin
            if (BURST) begin
                exp_aw_addr_q.push_back(addr);
                exp_aw_len_q.push_back(8'(n - 1));
            end else begin
                for (int k = 0; k < n; k++) begin
                    exp_aw_addr_q.push_back(addr + 64'(128 * k));
                    exp_aw_len_q.push_back(8'd0);
                end
            end
            for (int k = 0; k < n; k++) begin
                exp_w_data_q.push_back(sv[n - 1 - k]);
                exp_w_last_q.push_back(BURST ? (k == n - 1) : 1'b1);
            end
        end
        run_id++;
        start_cyc = cyc;
        store_start = 1; store_start_addr = addr; store_beat_num = 6'(n); store_pasid = cfg_pasid;
        @(negedge clk);
        store_start = 0;
        // scramble inputs: the DUT must work from its captured copy
        store_start_addr = {$urandom, $urandom}; store_pasid = 9'($urandom);
        for (int j = 0; j < SW / 32; j++) store_data[j*32 +: 32] = $urandom;
        chk("error_cleared_on_start", 64'(store_error), 0);
    endtask

    task automatic finish_store(input int n, input bit exp_error);
        int waited = 0;
        while (!store_done && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!store_done) begin
            chk("done_timeout", 0, 1);
        end else begin
            if (n == 0) chk("done_next_cycle", 64'(cyc), 64'(start_cyc + 1));
            else        chk("done_one_after_last_b", 64'(cyc), 64'(b_cyc + 1));
            chk("aw_count", 64'(aw_hs_n), 64'(exp_aw_total));
            chk("w_count", 64'(w_hs_n), 64'(n));
            chk("b_count", 64'(b_hs_n), 64'(cfg_b_total));
            chk("store_error", 64'(store_error), 64'(exp_error));
            @(negedge clk);
            $display("store n=%0d done at cycle %0d error=%0b", n, cyc, store_error);
            chk("done_level", 64'(store_done), 1);
        end
    endtask

    initial begin
        vec_t tbl [7];
        tbl[0] = '{n: 4,  addr: 64'h1000, stall: 0, err_last: 0, exp_error: 0};
        tbl[1] = '{n: 32, addr: 64'h2000, stall: 1, err_last: 0, exp_error: 0};
        tbl[2] = '{n: 0,  addr: 64'h3000, stall: 0, err_last: 0, exp_error: 0};
        tbl[3] = '{n: 2,  addr: 64'h4000, stall: 0, err_last: 1, exp_error: 1};
        tbl[4] = '{n: 1,  addr: 64'h5000, stall: 0, err_last: 0, exp_error: 0};
        tbl[5] = '{n: 8,  addr: 64'h6000, stall: 1, err_last: 0, exp_error: 0};
        tbl[6] = '{n: 17, addr: 64'h7000, stall: 1, err_last: 1, exp_error: 1};

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_awvalid", 64'(m_axi_awvalid), 0);
        chk("rst_wvalid", 64'(m_axi_wvalid), 0);
        chk("rst_done", 64'(store_done), 0);
        chk("rst_error", 64'(store_error), 0);
        chk("rst_awaddr", m_axi_awaddr, 0);
        chk("rst_awlen", 64'(m_axi_awlen), 0);
        chk("rst_wlast", 64'(m_axi_wlast), 0);
        chk("const_fields", {m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awlock,
                             m_axi_awprot, m_axi_awqos, m_axi_awregion, m_axi_bready},
            {3'd7, 2'b01, 4'd3, 1'b0, 3'd0, 4'd0, 4'd0, 1'b1});
        chk("const_wstrb_awid", {&m_axi_wstrb, m_axi_awid}, {1'b1, 1'b0});
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            start_store(tbl[i].n, tbl[i].addr, tbl[i].stall, tbl[i].err_last);
            finish_store(tbl[i].n, tbl[i].exp_error);
            if (i == 0) begin
                // a stray B while DONE must be ignored
                @(posedge clk); #1 force_b = 1;
                @(posedge clk); #1 force_b = 0;
                @(negedge clk);
                chk("stray_b_error", 64'(store_error), 0);
                chk("stray_b_done", 64'(store_done), 1);
            end
        end

        // repeated start while in RUN has no effect
        start_store(16, 64'h9000, 1, 0);
        repeat (2) @(negedge clk);
        store_start = 1; store_start_addr = 64'hDEAD0000; store_beat_num = 6'd5;
        @(negedge clk);
        store_start = 0;
        finish_store(16, 0);

        // reset in the middle of RUN
        start_store(8, 64'hA000, 1, 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 0;
        @(negedge clk);
        chk("midrst_awvalid", 64'(m_axi_awvalid), 0);
        chk("midrst_wvalid", 64'(m_axi_wvalid), 0);
        chk("midrst_done", 64'(store_done), 0);
        chk("midrst_error", 64'(store_error), 0);
        chk("midrst_awaddr", m_axi_awaddr, 0);
        chk("midrst_awlen", 64'(m_axi_awlen), 0);
        chk("midrst_wlast", 64'(m_axi_wlast), 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        start_store(1, 64'hB000, 0, 0);
        finish_store(1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sort_store.md
# sort_store

AXI4 write master that is the write-back stage of the hdl_sort engine. On a start pulse it captures a wide result vector, up to 32 × 1024-bit beats, and writes it to host memory at a given address. Data packing is the inverse of the sort fetch stage, so fetching N beats and storing them back to the same address is an identity. It reports completion only after every write response has returned.

## Interface
Parameters:
- ID_WIDTH, 1, AXI ID width; awid is tied to 0
- AWUSER_WIDTH, 9, width of awuser; carries the PASID
- PASID_WIDTH, 9, width of the PASID input
- STORE_WIDTH, 32768, width of the store_data vector (32 beats)
- DATA_WIDTH, 1024, AXI data width; fixed at 1024 (128 B per beat)
- ADDR_WIDTH, 64, AXI address width

Ports:
- clk, in, 1, clock
- rst_n, in, 1, reset; asynchronous, active-low
- store_start, in, 1, one-cycle pulse; ignored unless the state is IDLE or DONE
- store_start_addr, in, ADDR_WIDTH, byte address of beat 0; sampled on store_start
- store_pasid, in, PASID_WIDTH, sampled on store_start; drives awuser
- store_beat_num, in, 6, N = number of beats; legal range 0..32; sampled on store_start
- store_data, in, STORE_WIDTH, result vector; sampled on store_start
- store_done, out, 1, level; high in the DONE state
- store_error, out, 1, sticky; set by any non-OKAY bresp; cleared on store_start
- m_axi_aw{id,addr,len,size,burst,user,cache,lock,prot,qos,region,valid}, out, standard widths
- m_axi_awready, in, 1
- m_axi_w{data,strb,last,valid}, out, DATA_WIDTH / DATA_WIDTH/8 / 1 / 1
- m_axi_wready, in, 1
- m_axi_b{id,resp,valid}, in, ID_WIDTH / 2 / 1
- m_axi_bready, out, 1

## Operation
Constant AXI fields:
- awsize = 7, awburst = INCR, awcache = 3
- awprot, awqos, awregion and awlock = 0
- wstrb = all ones; bready = 1

Beat ordering:
- Beat k (k = 0..N-1) is written to addr + 128·k.
- Beat k carries store_data[(N-1-k)·1024 +: 1024], i.e. the first-fetched beat sits in the most significant used slice.

Counters:
- aw_cnt counts AW handshakes; w_cnt counts W handshakes; b_cnt counts B handshakes.
- All three are 6 bits wide and cleared on an accepted start.

States:
- IDLE (reset state)
  - An accepted start with N = 0 goes to DONE.
  - An accepted start with N > 0 captures the inputs and goes to RUN.
- RUN
  - awvalid = (aw_cnt < AW_total); awaddr = addr + 128·aw_cnt.
  - wvalid = (w_cnt < N); wdata is the slice for beat w_cnt.
  - The AW and W channels are independent; W may lead AW.
  - Exits to DONE when b_cnt == B_total, once the last B handshake completes.
- DONE
  - store_done = 1.
  - A new store_start re-enters the flow as described for IDLE.

Boundary rules:
- store_start in RUN is ignored; captured data, addr and counters are unchanged.
- A bvalid beyond B_total is ignored and does not increment b_cnt.
- A non-OKAY bresp still counts toward completion and sets store_error.
- Reset mid-operation: all counters go to 0, the state goes to IDLE, and all valids drop immediately.
- store_beat_num > 32 is illegal; behaviour is undefined.

## Timing
- Reset values:
  - awvalid, wvalid, store_done, store_error = 0
  - awaddr = 0, wlast = 0, awlen = 0
- awvalid and wvalid rise on the cycle after the accepted store_start.
- Valids hold until their handshake; payloads stay stable while valid is high.
- Back-to-back handshakes are supported: 1 beat/cycle with ready held high.
- store_done rises on the cycle after the final B handshake.
- Minimum latency, N = 1, always-ready slave with a same-cycle B: store_done at start + 3.

## Configuration
- SORT_STORE_BURST_EN defined:
  - One AW is issued with awlen = N-1; AW_total = B_total = 1.
  - wlast = 1 only on beat N-1.
- SORT_STORE_BURST_EN undefined:
  - N single-beat transactions with awlen = 0 and wlast = 1 on every beat; AW_total = B_total = N.
- The caller keeps the region within a 4 KB page; N ≤ 32 with a 4 KB-aligned address always satisfies this.

## Test plan
- N=4, addr 0x1000, slave always ready, bresp OKAY:
  - Unburst: AW addresses 0x1000/0x1080/0x1100/0x1180.
  - wdata order is slices 3, 2, 1, 0.
  - store_done rises one cycle after the 4th B.
- N=32 with random awready/wready/bvalid stalls, including W leading AW:
  - All 32 beats are correct.
  - Payloads stay stable under backpressure.
  - store_done rises only after b_cnt reaches B_total.
- N=0 → store_done on the next cycle, with no AW or W activity.
- N=2, second bresp = SLVERR → store_error = 1 and store_done = 1; the next store_start clears store_error.
- Repeat store_start mid-RUN → no effect.
- Assert rst_n low mid-RUN → all outputs return to reset values; a subsequent N=1 store completes normally.
- SORT_STORE_BURST_EN, N=8 → single AW with awlen = 7, wlast only on beat 7, one B, then store_done.
